// File: rtl/esc_pkg.sv
// rtl/esc_pkg.sv - shared constants and types for the ESC PWM interface
package esc_pkg;

  localparam int SPEED_W    = 11;
  localparam int OFFSET_DEF = 1000;
  localparam int SCALE_DEF  = 1;
  localparam int PERIOD_DEF = 8192;
  localparam int CNT_W_DEF  = 13;

  // Speed command type, also used by the motor-mix block
  typedef logic [SPEED_W-1:0] speed_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } esc_state_e;

endpackage

// File: rtl/esc_interface.sv
// rtl/esc_interface.sv - speed command to single-wire servo-style ESC PWM
module esc_interface #(
  parameter int SPEED_W = esc_pkg::SPEED_W,
  parameter int OFFSET  = esc_pkg::OFFSET_DEF,
  parameter int SCALE   = esc_pkg::SCALE_DEF,
  parameter int PERIOD  = esc_pkg::PERIOD_DEF,
  parameter int CNT_W   = esc_pkg::CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrt,
  input  logic [SPEED_W-1:0] SPEED,
  output logic               PWM
);

  import esc_pkg::esc_state_e;
  import esc_pkg::ST_IDLE;
  import esc_pkg::ST_ARMED;

  // A full-scale pulse must leave at least one low clock per frame
  if (PERIOD <= OFFSET + ((2 ** SPEED_W) - 1) * SCALE) begin : g_bad_period
    $error("esc_interface: PERIOD too short for full-scale pulse width");
  end
  if ((2 ** CNT_W) < PERIOD) begin : g_bad_cnt_w
    $error("esc_interface: CNT_W too narrow for PERIOD");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  esc_state_e         state, state_nxt;
  logic [SPEED_W-1:0] speed_reg, speed_nxt;
  logic [CNT_W-1:0]   frame_cnt, cnt_nxt;
  logic [CNT_W-1:0]   width;
  logic               pwm_nxt;

  // speed_reg only changes on wrt, which also restarts the frame
  assign width = CNT_W'(OFFSET) + CNT_W'(speed_reg) * CNT_W'(SCALE);

  always_comb begin
    state_nxt = state;
    speed_nxt = speed_reg;
    cnt_nxt   = frame_cnt;
    pwm_nxt   = 1'b0;
    if (wrt) begin
      state_nxt = ST_ARMED;
      speed_nxt = SPEED;
      cnt_nxt   = '0;
      pwm_nxt   = 1'b1;
    end else if (state == ST_ARMED) begin
      cnt_nxt = (frame_cnt == CNT_LAST) ? '0 : frame_cnt + 1'b1;
      pwm_nxt = (cnt_nxt < width);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      speed_reg <= '0;
      frame_cnt <= '0;
      PWM       <= 1'b0;
    end else begin
      state     <= state_nxt;
      speed_reg <= speed_nxt;
      frame_cnt <= cnt_nxt;
      PWM       <= pwm_nxt;
    end
  end

endmodule

// File: tb/tb_esc_interface.sv
// tb/tb_esc_interface.sv - scoreboard bench for esc_interface pulse widths and framing
module tb_esc_interface;

  logic        clk;
  logic        rst_n;
  logic        wrt;
  logic [10:0] SPEED;
  logic        PWM;

  int n_vec;
  int n_err;
  int exp_q[$];
  int pulse_len[$];
  int rise_idx[$];
  int high_cnt;
  int first_fall;

  esc_interface dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wrt   (wrt),
    .SPEED (SPEED),
    .PWM   (PWM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Samples PWM at n consecutive negedges; SPEED is scrambled meanwhile
  task automatic run_window(input int n);
    logic prev;
    int   start;
    high_cnt   = 0;
    first_fall = -1;
    prev       = 1'b0;
    start      = 0;
    rise_idx.delete();
    pulse_len.delete();
    for (int i = 0; i < n; i++) begin
      if (PWM === 1'b1) begin
        high_cnt++;
        if (!prev) begin
          rise_idx.push_back(i);
          start = i;
        end
        prev = 1'b1;
      end else begin
        if (prev) begin
          pulse_len.push_back(i - start);
          if (first_fall < 0) first_fall = i;
        end
        prev = 1'b0;
      end
      SPEED = 11'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic drain(input string name);
    int got;
    int exp;
    while (pulse_len.size() > 0) begin
      got = pulse_len.pop_front();
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL %s unexpected pulse: got %0d clocks, required none", name, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_err++;
          $display("FAIL %s pulse width: got %0d, required %0d", name, got, exp);
        end
      end
    end
    n_vec++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL %s missing pulses: got %0d outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Called at a negedge; returns at the next negedge with PWM expected high
  task automatic write_speed(input logic [10:0] s, input bit expect_pulse, input string name);
    wrt   = 1'b1;
    SPEED = s;
    @(negedge clk);
    wrt   = 1'b0;
    SPEED = 11'($urandom);
    if (expect_pulse) exp_q.push_back(1000 + int'(s));
    n_vec++;
    if (PWM !== 1'b1) begin
      n_err++;
      $display("FAIL %s rise after wrt: got %b, required 1", name, PWM);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wrt   = 1'b0;
    SPEED = 11'h000;
    repeat (3) begin
      @(negedge clk);
      n_vec++;
      if (PWM !== 1'b0) begin
        n_err++;
        $display("FAIL reset PWM in reset: got %b, required 0", PWM);
      end
    end
    rst_n = 1'b1;
    run_window(5000);
    n_vec++;
    if (high_cnt !== 0) begin
      n_err++;
      $display("FAIL reset idle high count: got %0d, required 0", high_cnt);
    end
  endtask

  task automatic test_min_speed();
    write_speed(11'h000, 1'b1, "min");
    run_window(5001);
    n_vec++;
    if (high_cnt !== 1000) begin
      n_err++;
      $display("FAIL min high count: got %0d, required 1000", high_cnt);
    end
    drain("min");
  endtask

  task automatic test_max_speed();
    write_speed(11'h7FF, 1'b1, "max");
    run_window(5001);
    n_vec++;
    if (high_cnt !== 3047) begin
      n_err++;
      $display("FAIL max high count: got %0d, required 3047", high_cnt);
    end
    n_vec++;
    if (first_fall !== 3047) begin
      n_err++;
      $display("FAIL max falling edge offset: got %0d, required 3047", first_fall);
    end
    drain("max");
  endtask

  task automatic test_random();
    logic [10:0] s;
    for (int k = 0; k < 10; k++) begin
      s = 11'($urandom_range(0, 2047));
      write_speed(s, 1'b1, "random");
      run_window(3200);
      n_vec++;
      if (high_cnt !== 1000 + int'(s)) begin
        n_err++;
        $display("FAIL random speed %0d high count: got %0d, required %0d", s, high_cnt, 1000 + int'(s));
      end
      drain("random");
    end
  endtask

  task automatic test_period();
    write_speed(11'h100, 1'b1, "period");
    exp_q.push_back(1256);
    run_window(16384);
    n_vec++;
    if (rise_idx.size() !== 2) begin
      n_err++;
      $display("FAIL period rising edges: got %0d, required 2", rise_idx.size());
    end else begin
      n_vec++;
      if (rise_idx[1] - rise_idx[0] !== 8192) begin
        n_err++;
        $display("FAIL period rise spacing: got %0d, required 8192", rise_idx[1] - rise_idx[0]);
      end
    end
    n_vec++;
    if (high_cnt !== 2512) begin
      n_err++;
      $display("FAIL period high count: got %0d, required 2512", high_cnt);
    end
    drain("period");
  endtask

  task automatic test_back_to_back();
    wrt   = 1'b1;
    SPEED = 11'h005;
    @(negedge clk);
    n_vec++;
    if (PWM !== 1'b1) begin
      n_err++;
      $display("FAIL b2b first write PWM: got %b, required 1", PWM);
    end
    SPEED = 11'h020;
    @(negedge clk);
    wrt   = 1'b0;
    SPEED = 11'($urandom);
    exp_q.push_back(1032);
    n_vec++;
    if (PWM !== 1'b1) begin
      n_err++;
      $display("FAIL b2b second write PWM: got %b, required 1", PWM);
    end
    run_window(1200);
    drain("b2b");
  endtask

  task automatic test_rewrite();
    int hi_old;
    write_speed(11'h7FF, 1'b0, "rewrite");
    run_window(499);
    hi_old = high_cnt;
    n_vec++;
    if (PWM !== 1'b1) begin
      n_err++;
      $display("FAIL rewrite PWM at strobe: got %b, required 1", PWM);
    end
    write_speed(11'h000, 1'b1, "rewrite");
    run_window(1100);
    n_vec++;
    if (hi_old + 1 + high_cnt !== 1500) begin
      n_err++;
      $display("FAIL rewrite total high: got %0d, required 1500", hi_old + 1 + high_cnt);
    end
    drain("rewrite");
  endtask

  task automatic test_reset_mid_pulse();
    write_speed(11'h7FF, 1'b0, "rstmid");
    run_window(100);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (PWM !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid async drop: got %b, required 0", PWM);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_window(2000);
    n_vec++;
    if (high_cnt !== 0) begin
      n_err++;
      $display("FAIL rstmid disarmed high count: got %0d, required 0", high_cnt);
    end
    write_speed(11'h010, 1'b1, "rstmid");
    run_window(1100);
    n_vec++;
    if (high_cnt !== 1016) begin
      n_err++;
      $display("FAIL rstmid rearm high count: got %0d, required 1016", high_cnt);
    end
    drain("rstmid");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_min_speed();
    test_max_speed();
    test_random();
    test_period();
    test_back_to_back();
    test_rewrite();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
